// File: rtl/ulbf_data_pkg.sv
// Shared types and sizing for the ulbf data AXI-Stream master.
package ulbf_data_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 12;
    localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ulbf_data_skid_fifo.sv
// Four-entry shift-style skid FIFO; entry 0 is always the head, so the
// read port comes straight from registers.
module ulbf_data_skid_fifo
    import ulbf_data_pkg::*;
#(
    parameter int unsigned WIDTH = 129
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]      mem_n [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q;
    logic [FIFO_DEPTH-1:0] vld_n;
    logic                  pop;
    logic                  placed;

    always_comb begin
        mem_n  = mem_q;
        vld_n  = vld_q;
        placed = 1'b0;
        pop    = vld_q[0] && rd_en;
        if (pop) begin
            for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
                mem_n[i] = mem_q[i+1];
                vld_n[i] = vld_q[i+1];
            end
            vld_n[FIFO_DEPTH-1] = 1'b0;
        end
        // Push lands in the first free slot after the pop has shifted.
        if (wr_en) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (!placed && !vld_n[i]) begin
                    mem_n[i] = wr_data;
                    vld_n[i] = 1'b1;
                    placed   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            vld_q <= '0;
        end else if (flush) begin
            mem_q <= '{default: '0};
            vld_q <= '0;
        end else begin
            mem_q <= mem_n;
            vld_q <= vld_n;
        end
    end

    assign rd_data  = mem_q[0];
    assign rd_valid = vld_q[0];

endmodule

// File: rtl/ulbf_data_axis_master.sv
// Streams block_size*niter BRAM rows out over AXI-Stream with tlast per block,
// using a credit-limited read pipeline in front of a 4-entry skid FIFO.
module ulbf_data_axis_master
    import ulbf_data_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic              m_axis_clk,
    input  logic              m_axis_resetn,
    input  logic              m_axis_rst,
    input  logic              go,
    input  logic [CNT_W-1:0]  block_size,
    input  logic [CNT_W-1:0]  niter,
    input  logic [ADDR_W-1:0] rollover_addr,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              done
);

    state_t             state_q, state_n;
    logic               go_q, go_edge;
    logic [CNT_W-1:0]   bs_q, nit_q;
    logic [ADDR_W-1:0]  roll_q, addr_q;
    logic [CNT_W-1:0]   iss_beat_q, iss_blk_q;
    logic [CNT_W-1:0]   acc_beat_q, acc_blk_q;
    logic [RAM_LAT-1:0] rd_pipe_q, last_pipe_q;
    logic [OCC_W-1:0]   fifo_occ;
    logic [DATA_W:0]    fifo_dout;
    int unsigned        pending;
    logic               credit_ok, issue, iss_last, iss_final, accept, acc_final;

    // Credit counts reads still in the BRAM pipe so the FIFO can never overflow.
    always_comb begin
        pending   = 32'(fifo_occ) + 32'($countones(rd_pipe_q));
        credit_ok = (pending < FIFO_DEPTH);
    end

    assign go_edge   = go && !go_q;
    assign issue     = (state_q == ST_RUN) && credit_ok;
    assign iss_last  = (iss_beat_q == bs_q - CNT_W'(1));
    assign iss_final = iss_last && (iss_blk_q == nit_q - CNT_W'(1));
    assign accept    = m_axis_tvalid && m_axis_tready;
    assign acc_final = accept && (acc_beat_q == bs_q - CNT_W'(1))
                       && (acc_blk_q == nit_q - CNT_W'(1));

    always_ff @(posedge m_axis_clk or negedge m_axis_resetn) begin
        if (!m_axis_resetn) begin
            state_q <= ST_IDLE;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            go_q    <= go;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go_edge) begin
                    state_n = (block_size == '0 || niter == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN:   if (issue && iss_final) state_n = ST_DRAIN;
            ST_DRAIN: if (acc_final)          state_n = ST_DONE;
            ST_DONE:  if (!go)                state_n = ST_IDLE;
            default:                          state_n = ST_IDLE;
        endcase
        if (m_axis_rst) state_n = ST_IDLE;
    end

    always_ff @(posedge m_axis_clk or negedge m_axis_resetn) begin
        if (!m_axis_resetn) begin
            bs_q        <= '0;
            nit_q       <= '0;
            roll_q      <= '0;
            addr_q      <= '0;
            iss_beat_q  <= '0;
            iss_blk_q   <= '0;
            acc_beat_q  <= '0;
            acc_blk_q   <= '0;
            rd_pipe_q   <= '0;
            last_pipe_q <= '0;
        end else if (m_axis_rst) begin
            addr_q      <= '0;
            iss_beat_q  <= '0;
            iss_blk_q   <= '0;
            acc_beat_q  <= '0;
            acc_blk_q   <= '0;
            rd_pipe_q   <= '0;
            last_pipe_q <= '0;
        end else begin
            if (state_q == ST_IDLE && go_edge) begin
                bs_q       <= block_size;
                nit_q      <= niter;
                roll_q     <= rollover_addr;
                addr_q     <= '0;
                iss_beat_q <= '0;
                iss_blk_q  <= '0;
                acc_beat_q <= '0;
                acc_blk_q  <= '0;
            end
            // roll_q of 0 makes roll_q-1 all ones, i.e. the natural 2^ADDR_W wrap.
            if (issue) begin
                addr_q <= (addr_q == roll_q - ADDR_W'(1)) ? '0 : addr_q + ADDR_W'(1);
                if (iss_last) begin
                    iss_beat_q <= '0;
                    iss_blk_q  <= iss_blk_q + CNT_W'(1);
                end else begin
                    iss_beat_q <= iss_beat_q + CNT_W'(1);
                end
            end
            rd_pipe_q   <= RAM_LAT'({rd_pipe_q, issue});
            last_pipe_q <= RAM_LAT'({last_pipe_q, issue && iss_last});
            if (accept) begin
                if (acc_beat_q == bs_q - CNT_W'(1)) begin
                    acc_beat_q <= '0;
                    acc_blk_q  <= acc_blk_q + CNT_W'(1);
                end else begin
                    acc_beat_q <= acc_beat_q + CNT_W'(1);
                end
            end
        end
    end

    ulbf_data_skid_fifo #(
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk      (m_axis_clk),
        .rst_n    (m_axis_resetn),
        .flush    (m_axis_rst),
        .wr_en    (rd_pipe_q[RAM_LAT-1]),
        .wr_data  ({last_pipe_q[RAM_LAT-1], doutb}),
        .rd_en    (m_axis_tready),
        .rd_data  (fifo_dout),
        .rd_valid (m_axis_tvalid),
        .occupancy(fifo_occ)
    );

    assign m_axis_tdata = fifo_dout[DATA_W-1:0];
    assign m_axis_tlast = fifo_dout[DATA_W];
    assign enb          = issue;
    assign addrb        = addr_q;
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_ulbf_data_axis_master.sv
// Directed bench for ulbf_data_axis_master with a BRAM model and beat/address scoreboards.
module tb_ulbf_data_axis_master;

    localparam int unsigned DW  = 128;
    localparam int unsigned AW  = 16;
    localparam int unsigned LAT = 2;

    logic          m_axis_clk = 1'b0;
    logic          m_axis_resetn;
    logic          m_axis_rst;
    logic          go;
    logic [11:0]   block_size;
    logic [11:0]   niter;
    logic [AW-1:0] rollover_addr;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          done;

    ulbf_data_axis_master #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .RAM_LAT(LAT)
    ) dut (
        .m_axis_clk   (m_axis_clk),
        .m_axis_resetn(m_axis_resetn),
        .m_axis_rst   (m_axis_rst),
        .go           (go),
        .block_size   (block_size),
        .niter        (niter),
        .rollover_addr(rollover_addr),
        .enb          (enb),
        .addrb        (addrb),
        .doutb        (doutb),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .done         (done)
    );

    always #5 m_axis_clk = ~m_axis_clk;

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {16'h0, a};
        return {w * 32'h9E37_79B1, w ^ 32'hDEAD_BEEF, 16'hC0DE, a, w + 32'h0001_2345};
    endfunction

    logic [DW-1:0] bram_r [LAT];
    always @(posedge m_axis_clk) begin
        if (enb) bram_r[0] <= bram_word(addrb);
        for (int i = 1; i < LAT; i++) bram_r[i] <= bram_r[i-1];
    end
    assign doutb = bram_r[LAT-1];

    int cyc = 0;
    always @(posedge m_axis_clk) cyc <= cyc + 1;

    int npass  = 0;
    int ntotal = 0;
    int nfail  = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [DW:0]   exp_beat [$];
    logic [AW-1:0] exp_addr [$];
    bit            mon_on = 1'b0;
    bit            seen_tv, stalled;
    int            tready_mode = 0;
    int            stop_at = 0;
    int            acc_cnt, first_tv, last_acc, cyc0;
    logic [DW-1:0] held_data;
    logic          held_last;

    always @(negedge m_axis_clk) begin
        logic [DW:0]   eb;
        logic [AW-1:0] ea;
        if (!mon_on) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_tvalid", 160'(m_axis_tvalid), 160'(1));
                check("hold_tdata", 160'(m_axis_tdata), 160'(held_data));
                check("hold_tlast", 160'(m_axis_tlast), 160'(held_last));
            end
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = (acc_cnt < stop_at);
            endcase
            if (m_axis_tvalid && !seen_tv) begin
                seen_tv  = 1'b1;
                first_tv = cyc;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", 160'(exp_beat.size() != 0), 160'(1));
                if (exp_beat.size() != 0) begin
                    eb = exp_beat.pop_front();
                    check("tdata", 160'(m_axis_tdata), 160'(eb[DW-1:0]));
                    check("tlast", 160'(m_axis_tlast), 160'(eb[DW]));
                end
                acc_cnt++;
                last_acc = cyc;
                stalled  = 1'b0;
            end else if (m_axis_tvalid) begin
                stalled   = 1'b1;
                held_data = m_axis_tdata;
                held_last = m_axis_tlast;
            end else begin
                stalled = 1'b0;
            end
            if (enb) begin
                check("read_expected", 160'(exp_addr.size() != 0), 160'(1));
                if (exp_addr.size() != 0) begin
                    ea = exp_addr.pop_front();
                    check("addrb", 160'(addrb), 160'(ea));
                end
            end
        end
    end

    task automatic sb_flush();
        exp_beat.delete();
        exp_addr.delete();
        stalled = 1'b0;
    endtask

    task automatic start_run(input int bs, input int ni, input logic [AW-1:0] roll);
        logic [AW-1:0] a;
        a = '0;
        for (int k = 0; k < bs * ni; k++) begin
            exp_addr.push_back(a);
            exp_beat.push_back({(k % bs) == (bs - 1), bram_word(a)});
            a = (a == roll - 1'b1) ? '0 : a + 1'b1;
        end
        @(posedge m_axis_clk); #1;
        seen_tv = 1'b0;
        acc_cnt = 0;
        stalled = 1'b0;
        mon_on  = 1'b1;
        block_size    = bs[11:0];
        niter         = ni[11:0];
        rollover_addr = roll;
        go            = 1'b1;
        cyc0          = cyc;
        @(posedge m_axis_clk); #1;
        // Scribble over the CSR inputs; the run must use the latched copies.
        block_size    = 12'd1;
        niter         = 12'd1;
        rollover_addr = 16'd1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge m_axis_clk);
            n++;
        end
        check("done_rise", 160'(done), 160'(1));
        check("beats_left", 160'(exp_beat.size()), 160'(0));
        check("reads_left", 160'(exp_addr.size()), 160'(0));
    endtask

    task automatic release_go();
        @(posedge m_axis_clk); #1;
        go = 1'b0;
        @(posedge m_axis_clk); #1;
        check("done_fall", 160'(done), 160'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enb"},    160'(enb), 160'(0));
        check({tag, "_addrb"},  160'(addrb), 160'(0));
        check({tag, "_tvalid"}, 160'(m_axis_tvalid), 160'(0));
        check({tag, "_tlast"},  160'(m_axis_tlast), 160'(0));
        check({tag, "_tdata"},  160'(m_axis_tdata), 160'(0));
        check({tag, "_done"},   160'(done), 160'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_axis_resetn = 1'b1;
        m_axis_rst    = 1'b0;
        go            = 1'b0;
        block_size    = '0;
        niter         = '0;
        rollover_addr = '0;
        m_axis_tready = 1'b0;
        #1 m_axis_resetn = 1'b0;
        repeat (3) @(posedge m_axis_clk);
        #1;
        check_reset_outputs("por");
        m_axis_resetn = 1'b1;

        // 4x3 at full rate: latency, back-to-back beats, tlast on 4/8/12
        tready_mode = 0;
        start_run(4, 3, 16'd1536);
        wait_done(100);
        check("t1_first_tvalid_lat", 160'(first_tv - cyc0), 160'(LAT + 2));
        check("t1_burst_cycles", 160'(last_acc - first_tv), 160'(11));
        check("t1_beats", 160'(acc_cnt), 160'(12));
        repeat (5) @(negedge m_axis_clk);
        check("t1_done_held", 160'(done), 160'(1));
        release_go();

        // address wrap at rollover 5
        start_run(4, 2, 16'd5);
        wait_done(100);
        check("t2_first_tvalid_lat", 160'(first_tv - cyc0), 160'(LAT + 2));
        check("t2_burst_cycles", 160'(last_acc - first_tv), 160'(7));
        release_go();

        // long run, random backpressure, rollover 0 meaning full space
        tready_mode = 2;
        start_run(384, 4, 16'd0);
        wait_done(20000);
        check("t3_beats", 160'(acc_cnt), 160'(1536));
        release_go();

        // empty runs: niter 0 then block_size 0
        tready_mode = 0;
        start_run(4, 0, 16'd1536);
        wait_done(3);
        repeat (3) @(negedge m_axis_clk);
        check("t4a_no_tvalid", 160'(seen_tv), 160'(0));
        release_go();
        start_run(0, 5, 16'd1536);
        wait_done(3);
        check("t4b_no_tvalid", 160'(seen_tv), 160'(0));
        release_go();

        // soft reset while stalled after beat 100
        tready_mode = 3;
        stop_at     = 100;
        start_run(384, 4, 16'd0);
        n = 0;
        while (acc_cnt < 100 && n < 2000) begin
            @(negedge m_axis_clk);
            n++;
        end
        repeat (10) @(negedge m_axis_clk);
        check("t5_beats_before_rst", 160'(acc_cnt), 160'(100));
        @(posedge m_axis_clk); #1;
        mon_on     = 1'b0;
        m_axis_rst = 1'b1;
        @(posedge m_axis_clk); #1;
        m_axis_rst = 1'b0;
        sb_flush();
        check("t5_tvalid", 160'(m_axis_tvalid), 160'(0));
        check("t5_addrb", 160'(addrb), 160'(0));
        check("t5_done", 160'(done), 160'(0));
        check("t5_enb", 160'(enb), 160'(0));
        go = 1'b0;
        @(posedge m_axis_clk); #1;
        tready_mode = 0;
        start_run(4, 3, 16'd1536);
        wait_done(100);
        check("t5_restart_beats", 160'(acc_cnt), 160'(12));
        release_go();

        // asynchronous reset mid-run, checked before any clock edge
        tready_mode = 2;
        start_run(384, 4, 16'd1536);
        repeat (200) @(negedge m_axis_clk);
        @(posedge m_axis_clk); #3;
        mon_on        = 1'b0;
        m_axis_resetn = 1'b0;
        go            = 1'b0;
        #1;
        check_reset_outputs("async");
        sb_flush();
        @(posedge m_axis_clk); #1;
        m_axis_resetn = 1'b1;
        tready_mode   = 0;
        start_run(2, 2, 16'd3);
        wait_done(100);
        check("t6_recover_beats", 160'(acc_cnt), 160'(4));
        release_go();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
